// File: rtl/c2c_pkg.sv
// Shared definitions for the chip2chip link controllers (master and slave side).
// Holds the FSM encoding, default bring-up timing and an output decoder.
package c2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PMA_RST = 3'd1,
    ST_PB_RST  = 3'd2,
    ST_WAIT_UP = 3'd3,
    ST_STABLE  = 3'd4,
    ST_READY   = 3'd5,
    ST_FAIL    = 3'd6
  } c2c_state_t;

  localparam int DEF_PMA_INIT_CYCLES   = 1024;
  localparam int DEF_RESET_PB_CYCLES   = 256;
  localparam int DEF_UP_TIMEOUT_CYCLES = 1048576;
  localparam int DEF_STABLE_CYCLES     = 4096;
  localparam int DEF_MAX_RETRIES       = 7;

  typedef struct packed {
    logic pma_init;
    logic reset_pb;
    logic c2c_aresetn;
    logic link_ready;
    logic link_fail;
  } c2c_ctrl_t;

  // Control outputs that belong to each state; anything not in a reset or
  // ready state keeps the core in reset so an unknown state fails safe.
  function automatic c2c_ctrl_t c2c_state_outputs(input c2c_state_t st);
    c2c_ctrl_t o;
    o = '{pma_init: 1'b1, reset_pb: 1'b1, c2c_aresetn: 1'b0,
          link_ready: 1'b0, link_fail: 1'b0};
    case (st)
      ST_PB_RST: o.pma_init = 1'b0;
      ST_WAIT_UP, ST_STABLE: begin
        o.pma_init = 1'b0;
        o.reset_pb = 1'b0;
      end
      ST_READY: begin
        o.pma_init    = 1'b0;
        o.reset_pb    = 1'b0;
        o.c2c_aresetn = 1'b1;
        o.link_ready  = 1'b1;
      end
      ST_FAIL: o.link_fail = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic int c2c_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/c2c_sync2.sv
// Two-flop synchronizer for one asynchronous level into the aclk domain.
module c2c_sync2 (
  input  logic aclk,
  input  logic aresetn,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the async level, then re-register to let metastability settle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/c2c_master_link_ctrl.sv
// Master-side Aurora/chip2chip bring-up controller: sequences PMA and
// push-button resets, waits for channel-up, qualifies stability, then
// releases the chip2chip master; retries a bounded number of times.
module c2c_master_link_ctrl
  import c2c_pkg::*;
#(
  parameter int PMA_INIT_CYCLES   = DEF_PMA_INIT_CYCLES,
  parameter int RESET_PB_CYCLES   = DEF_RESET_PB_CYCLES,
  parameter int UP_TIMEOUT_CYCLES = DEF_UP_TIMEOUT_CYCLES,
  parameter int STABLE_CYCLES     = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES       = DEF_MAX_RETRIES
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       enable,
  input  logic       channel_up,
  input  logic [1:0] lane_up,
  input  logic       hard_err,
  output logic       pma_init,
  output logic       reset_pb,
  output logic       c2c_aresetn,
  output logic       link_ready,
  output logic       link_fail,
  output logic [2:0] retry_count,
  output logic [7:0] drop_count,
  output logic [2:0] state
);

  localparam int MAX_CYC = c2c_max(c2c_max(PMA_INIT_CYCLES, RESET_PB_CYCLES),
                                   c2c_max(UP_TIMEOUT_CYCLES, STABLE_CYCLES));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LOAD_PMA    = CNT_W'(PMA_INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_PB     = CNT_W'(RESET_PB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_UP     = CNT_W'(UP_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_STABLE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRIES);

  logic [3:0]       raw_in;
  logic [3:0]       sync_in;
  logic             link_ok;
  logic             fault;
  logic             do_retry;
  c2c_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       retry_reg, retry_next;
  logic [7:0]       drop_reg, drop_next;
  c2c_ctrl_t        ctrl_reg;

  // Bit order: {hard_err, channel_up, lane_up[1], lane_up[0]}.
  assign raw_in = {hard_err, channel_up, lane_up};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      c2c_sync2 u_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .d       (raw_in[gi]),
        .q       (sync_in[gi])
      );
    end
  endgenerate

  assign link_ok = sync_in[2] & (&sync_in[1:0]);
  assign fault   = ~link_ok | sync_in[3];

  // Next-state, shared timer, retry and drop bookkeeping.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    drop_next  = drop_reg;
    do_retry   = 1'b0;

    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_PMA_RST;
        ST_PMA_RST: begin
          if (cnt_reg == '0) state_next = ST_PB_RST;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        ST_PB_RST: begin
          if (cnt_reg == '0) state_next = ST_WAIT_UP;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        ST_WAIT_UP: begin
          if (link_ok)             state_next = ST_STABLE;
          else if (cnt_reg == '0)  do_retry   = 1'b1;
          else                     cnt_next   = cnt_reg - 1'b1;
        end
        ST_STABLE: begin
          if (fault)              do_retry   = 1'b1;
          else if (cnt_reg == '0) state_next = ST_READY;
          else                    cnt_next   = cnt_reg - 1'b1;
        end
        ST_READY: begin
          // One drop per exit, however many fault sources fire together.
          if (fault) begin
            do_retry = 1'b1;
            if (drop_reg != 8'hFF) drop_next = drop_reg + 8'd1;
          end
        end
        ST_FAIL: ;
        default: state_next = ST_IDLE;
      endcase
    end

    if (do_retry) begin
      if (retry_reg == RETRY_LIMIT) begin
        state_next = ST_FAIL;
      end else begin
        retry_next = retry_reg + 3'd1;
        state_next = ST_PMA_RST;
      end
    end

    if (state_next == ST_IDLE) retry_next = 3'd0;

    // Every state entry restarts the shared timer for the new state.
    if (state_next != state_reg) begin
      case (state_next)
        ST_PMA_RST: cnt_next = LOAD_PMA;
        ST_PB_RST:  cnt_next = LOAD_PB;
        ST_WAIT_UP: cnt_next = LOAD_UP;
        ST_STABLE:  cnt_next = LOAD_STABLE;
        default:    cnt_next = '0;
      endcase
    end
  end

  // State and outputs register together so outputs track state entry exactly.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      retry_reg <= 3'd0;
      drop_reg  <= 8'd0;
      ctrl_reg  <= c2c_state_outputs(ST_IDLE);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      drop_reg  <= drop_next;
      ctrl_reg  <= c2c_state_outputs(state_next);
    end
  end

  assign pma_init    = ctrl_reg.pma_init;
  assign reset_pb    = ctrl_reg.reset_pb;
  assign c2c_aresetn = ctrl_reg.c2c_aresetn;
  assign link_ready  = ctrl_reg.link_ready;
  assign link_fail   = ctrl_reg.link_fail;
  assign retry_count = retry_reg;
  assign drop_count  = drop_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_c2c_master_link_ctrl.sv
// Bench for c2c_master_link_ctrl: expected state visits (outputs plus dwell)
// are queued by each scenario and retired by a transition monitor.
module tb_c2c_master_link_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PMA   = 3'd1;
  localparam logic [2:0] S_PB    = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STAB  = 3'd4;
  localparam logic [2:0] S_READY = 3'd5;
  localparam logic [2:0] S_FAIL  = 3'd6;

  logic       aclk;
  logic       aresetn;
  logic       enable;
  logic       channel_up;
  logic [1:0] lane_up;
  logic       hard_err;
  logic       pma_init;
  logic       reset_pb;
  logic       c2c_aresetn;
  logic       link_ready;
  logic       link_fail;
  logic [2:0] retry_count;
  logic [7:0] drop_count;
  logic [2:0] state;

  c2c_master_link_ctrl #(
    .PMA_INIT_CYCLES   (8),
    .RESET_PB_CYCLES   (4),
    .UP_TIMEOUT_CYCLES (64),
    .STABLE_CYCLES     (16),
    .MAX_RETRIES       (2)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .enable      (enable),
    .channel_up  (channel_up),
    .lane_up     (lane_up),
    .hard_err    (hard_err),
    .pma_init    (pma_init),
    .reset_pb    (reset_pb),
    .c2c_aresetn (c2c_aresetn),
    .link_ready  (link_ready),
    .link_fail   (link_fail),
    .retry_count (retry_count),
    .drop_count  (drop_count),
    .state       (state)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [2:0] st;
    logic       pma;
    logic       pb;
    logic       c2c;
    logic       rdy;
    logic       fail;
    logic [2:0] retry;
    logic [7:0] drop;
    int         dwell;   // cycles expected in this state, -1 = unchecked
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_pop;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mon_on = 1'b0;
  logic        saw_ready = 1'b0;
  logic [2:0]  prev_state = 3'd0;
  int          dwell_cnt = 0;
  int          cur_dwell = -1;
  logic [18:0] obs_v;
  logic [18:0] req_v;

  function automatic exp_t mk_exp(input logic [2:0] st, input logic [2:0] r,
                                  input logic [7:0] d, input int dw);
    exp_t x;
    x.st    = st;
    x.retry = r;
    x.drop  = d;
    x.dwell = dw;
    x.pma   = (st == S_IDLE) || (st == S_PMA) || (st == S_FAIL);
    x.pb    = (st == S_IDLE) || (st == S_PMA) || (st == S_PB) || (st == S_FAIL);
    x.c2c   = (st == S_READY);
    x.rdy   = (st == S_READY);
    x.fail  = (st == S_FAIL);
    return x;
  endfunction

  // Transition monitor: retires one queued expectation per state change.
  always @(negedge aclk) begin
    if (mon_on) begin
      dwell_cnt++;
      if (link_ready === 1'b1) saw_ready = 1'b1;
      if (state !== prev_state) begin
        if (cur_dwell >= 0) begin
          n_cmp++;
          if (dwell_cnt !== cur_dwell) begin
            n_bad++;
            $display("FAIL dwell state=%0d actual=%0d required=%0d", prev_state, dwell_cnt, cur_dwell);
          end
        end
        obs_v = {state, pma_init, reset_pb, c2c_aresetn, link_ready, link_fail, retry_count, drop_count};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          cur_dwell = -1;
          $display("FAIL unexpected_transition actual=%0d->%0d required=none", prev_state, state);
        end else begin
          e_pop = exp_q.pop_front();
          req_v = {e_pop.st, e_pop.pma, e_pop.pb, e_pop.c2c, e_pop.rdy, e_pop.fail, e_pop.retry, e_pop.drop};
          cur_dwell = e_pop.dwell;
          if (obs_v !== req_v) begin
            n_bad++;
            $display("FAIL transition actual=%05h required=%05h", obs_v, req_v);
          end
        end
        $display("TRANS t=%0t state=%0d->%0d pma=%0b pb=%0b c2c=%0b rdy=%0b fail=%0b retry=%0d drop=%0d",
                 $time, prev_state, state, pma_init, reset_pb, c2c_aresetn, link_ready, link_fail,
                 retry_count, drop_count);
        prev_state = state;
        dwell_cnt  = 0;
      end
    end
  end

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== st && n < budget) begin
      @(negedge aclk);
      n++;
    end
    if (state !== st) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout state actual=%0d required=%0d", tag, state, st);
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge aclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain pending actual=%0d required=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_cmp++; if (state !== S_IDLE)     begin n_bad++; $display("FAIL reset_state actual=%0d required=0", state); end
    n_cmp++; if (pma_init !== 1'b1)    begin n_bad++; $display("FAIL reset_pma_init actual=%0b required=1", pma_init); end
    n_cmp++; if (reset_pb !== 1'b1)    begin n_bad++; $display("FAIL reset_reset_pb actual=%0b required=1", reset_pb); end
    n_cmp++; if (c2c_aresetn !== 1'b0) begin n_bad++; $display("FAIL reset_c2c_aresetn actual=%0b required=0", c2c_aresetn); end
    n_cmp++; if (link_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_link_ready actual=%0b required=0", link_ready); end
    n_cmp++; if (link_fail !== 1'b0)   begin n_bad++; $display("FAIL reset_link_fail actual=%0b required=0", link_fail); end
    n_cmp++; if (retry_count !== 3'd0) begin n_bad++; $display("FAIL reset_retry actual=%0d required=0", retry_count); end
    n_cmp++; if (drop_count !== 8'd0)  begin n_bad++; $display("FAIL reset_drop actual=%0d required=0", drop_count); end
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL idle_hold state actual=%0d required=0", state); end
    prev_state = state;
    mon_on = 1'b1;
  endtask

  task automatic test_nominal();
    exp_q.push_back(mk_exp(S_PMA,   3'd0, 8'd0, 8));
    exp_q.push_back(mk_exp(S_PB,    3'd0, 8'd0, 4));
    exp_q.push_back(mk_exp(S_WAIT,  3'd0, 8'd0, 12));
    exp_q.push_back(mk_exp(S_STAB,  3'd0, 8'd0, 16));
    exp_q.push_back(mk_exp(S_READY, 3'd0, 8'd0, -1));
    saw_ready = 1'b0;
    @(posedge aclk); #1;
    enable = 1'b1;
    wait_state(S_WAIT, 40, "nominal_wait_up");
    repeat (9) @(posedge aclk);
    #1;
    channel_up = 1'b1;
    lane_up    = 2'b11;
    wait_state(S_READY, 60, "nominal_ready");
    wait_drain(10, "nominal");
    @(negedge aclk);
    n_cmp++; if (link_ready !== 1'b1)  begin n_bad++; $display("FAIL nominal_link_ready actual=%0b required=1", link_ready); end
    n_cmp++; if (c2c_aresetn !== 1'b1) begin n_bad++; $display("FAIL nominal_c2c_aresetn actual=%0b required=1", c2c_aresetn); end
    n_cmp++; if (retry_count !== 3'd0) begin n_bad++; $display("FAIL nominal_retry actual=%0d required=0", retry_count); end
  endtask

  task automatic test_drop();
    exp_q.push_back(mk_exp(S_PMA,   3'd1, 8'd1, 8));
    exp_q.push_back(mk_exp(S_PB,    3'd1, 8'd1, 4));
    exp_q.push_back(mk_exp(S_WAIT,  3'd1, 8'd1, 1));
    exp_q.push_back(mk_exp(S_STAB,  3'd1, 8'd1, 16));
    exp_q.push_back(mk_exp(S_READY, 3'd1, 8'd1, -1));
    @(posedge aclk); #1;
    hard_err   = 1'b1;
    channel_up = 1'b0;
    wait_state(S_PMA, 20, "drop_exit");
    n_cmp++; if (c2c_aresetn !== 1'b0) begin n_bad++; $display("FAIL drop_c2c_aresetn actual=%0b required=0", c2c_aresetn); end
    hard_err   = 1'b0;
    channel_up = 1'b1;
    wait_state(S_READY, 80, "drop_rebringup");
    wait_drain(10, "drop");
    @(negedge aclk);
    n_cmp++; if (drop_count !== 8'd1) begin n_bad++; $display("FAIL drop_count actual=%0d required=1", drop_count); end
    n_cmp++; if (link_ready !== 1'b1) begin n_bad++; $display("FAIL drop_relink actual=%0b required=1", link_ready); end
  endtask

  task automatic test_abort_reset();
    exp_q.push_back(mk_exp(S_IDLE, 3'd0, 8'd0, -1));
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    n_cmp++; if (state !== S_IDLE)     begin n_bad++; $display("FAIL rst_abort_state actual=%0d required=0", state); end
    n_cmp++; if (pma_init !== 1'b1)    begin n_bad++; $display("FAIL rst_abort_pma_init actual=%0b required=1", pma_init); end
    n_cmp++; if (reset_pb !== 1'b1)    begin n_bad++; $display("FAIL rst_abort_reset_pb actual=%0b required=1", reset_pb); end
    n_cmp++; if (link_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_abort_link_ready actual=%0b required=0", link_ready); end
    n_cmp++; if (drop_count !== 8'd0)  begin n_bad++; $display("FAIL rst_abort_drop actual=%0d required=0", drop_count); end
    enable     = 1'b0;
    channel_up = 1'b0;
    lane_up    = 2'b00;
    hard_err   = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    wait_drain(10, "abort_reset");
    repeat (3) @(posedge aclk);
  endtask

  task automatic test_abort_enable();
    exp_q.push_back(mk_exp(S_PMA,  3'd0, 8'd0, 8));
    exp_q.push_back(mk_exp(S_PB,   3'd0, 8'd0, 2));
    exp_q.push_back(mk_exp(S_IDLE, 3'd0, 8'd0, -1));
    @(posedge aclk); #1;
    enable = 1'b1;
    wait_state(S_PB, 30, "abort_pb");
    @(posedge aclk); #1;
    enable = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    n_cmp++; if (state !== S_IDLE)  begin n_bad++; $display("FAIL en_abort_state actual=%0d required=0", state); end
    n_cmp++; if (pma_init !== 1'b1) begin n_bad++; $display("FAIL en_abort_pma_init actual=%0b required=1", pma_init); end
    n_cmp++; if (reset_pb !== 1'b1) begin n_bad++; $display("FAIL en_abort_reset_pb actual=%0b required=1", reset_pb); end
    wait_drain(10, "abort_enable");
  endtask

  task automatic test_flap();
    exp_q.push_back(mk_exp(S_PMA,  3'd0, 8'd0, 8));
    exp_q.push_back(mk_exp(S_PB,   3'd0, 8'd0, 4));
    exp_q.push_back(mk_exp(S_WAIT, 3'd0, 8'd0, 12));
    exp_q.push_back(mk_exp(S_STAB, 3'd0, 8'd0, 10));
    exp_q.push_back(mk_exp(S_PMA,  3'd1, 8'd0, 2));
    exp_q.push_back(mk_exp(S_IDLE, 3'd0, 8'd0, -1));
    saw_ready = 1'b0;
    @(posedge aclk); #1;
    enable = 1'b1;
    wait_state(S_WAIT, 40, "flap_wait_up");
    repeat (9) @(posedge aclk);
    #1;
    channel_up = 1'b1;
    lane_up    = 2'b11;
    wait_state(S_STAB, 20, "flap_stable");
    repeat (7) @(posedge aclk);
    #1;
    channel_up = 1'b0;
    wait_state(S_PMA, 30, "flap_retry");
    n_cmp++; if (retry_count !== 3'd1) begin n_bad++; $display("FAIL flap_retry actual=%0d required=1", retry_count); end
    @(posedge aclk); #1;
    enable  = 1'b0;
    lane_up = 2'b00;
    wait_drain(10, "flap");
    n_cmp++; if (saw_ready !== 1'b0) begin n_bad++; $display("FAIL flap_link_ready_seen actual=%0b required=0", saw_ready); end
  endtask

  task automatic test_timeout();
    for (int a = 0; a < 3; a++) begin
      exp_q.push_back(mk_exp(S_PMA,  3'(a), 8'd0, 8));
      exp_q.push_back(mk_exp(S_PB,   3'(a), 8'd0, 4));
      exp_q.push_back(mk_exp(S_WAIT, 3'(a), 8'd0, 64));
    end
    exp_q.push_back(mk_exp(S_FAIL, 3'd2, 8'd0, -1));
    exp_q.push_back(mk_exp(S_IDLE, 3'd0, 8'd0, -1));
    @(posedge aclk); #1;
    enable = 1'b1;
    wait_state(S_FAIL, 600, "timeout_fail");
    n_cmp++; if (link_fail !== 1'b1) begin n_bad++; $display("FAIL timeout_link_fail actual=%0b required=1", link_fail); end
    repeat (5) @(negedge aclk);
    n_cmp++; if (state !== S_FAIL) begin n_bad++; $display("FAIL fail_hold state actual=%0d required=6", state); end
    @(posedge aclk); #1;
    enable = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    n_cmp++; if (state !== S_IDLE)     begin n_bad++; $display("FAIL timeout_idle state actual=%0d required=0", state); end
    n_cmp++; if (retry_count !== 3'd0) begin n_bad++; $display("FAIL timeout_retry_clear actual=%0d required=0", retry_count); end
    wait_drain(10, "timeout");
  endtask

  initial begin
    aresetn    = 1'b1;
    enable     = 1'b0;
    channel_up = 1'b0;
    lane_up    = 2'b00;
    hard_err   = 1'b0;
    test_reset();
    test_nominal();
    test_drop();
    test_abort_reset();
    test_abort_enable();
    test_flap();
    test_timeout();
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
